id_ex_pipe: RTL and testbench
=============================

# id_ex_pipe

ID/EX pipeline register for the 5-stage MIPS core, directly downstream of the decode control unit. It latches the control bundle, register operands, immediate and register numbers at the end of ID. It detects load-use hazards against the instruction it currently holds and drives the hazard line that makes the control unit emit zeroed controls. It inserts the resulting bubble itself, supports a global pipeline stall, and counts inserted bubbles for performance monitoring.

## Interface
- CNT_W, 16, width of the saturating bubble counter
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous and active-high
- Stall_i  in  1  global pipeline stall (e.g. memory wait); holds this register
- RegDst_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemWrite_i, MemRead_i  in  1 each  control bits from decode
- ALUOp_i  in  2  ALU operation class from decode
- RS_data_i, RT_data_i  in  32  register file read data
- Imm_i  in  32  sign-extended immediate
- RS_addr_i, RT_addr_i, RD_addr_i  in  5  instruction register fields in ID
- RegDst_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemWrite_o, MemRead_o  out  1 each  registered control bits for EX
- ALUOp_o  out  2  registered ALU operation class
- RS_data_o, RT_data_o, Imm_o  out  32  registered operands
- RS_addr_o, RT_addr_o, RD_addr_o  out  5  registered register numbers (forwarding/write-back select)
- Valid_o  out  1  1 = EX holds a real instruction, 0 = bubble
- Hazard_o  out  1  load-use hazard, combinational; drives decode Hazard_i
- PCWrite_o, IFIDWrite_o  out  1 each  write enables for PC and IF/ID; both equal ~(Hazard_o | Stall_i)
- Bubble_cnt_o  out  CNT_W  number of hazard bubbles inserted, saturating

## Operation
- Hazard_o = Valid_o & MemRead_o & (RT_addr_o != 0) & ((RT_addr_o == RS_addr_i) | (RT_addr_o == RT_addr_i)).
- The RT comparison is deliberately conservative: an I-type instruction in ID whose rt is a destination may cause a false one-cycle stall.
- Per-edge priority, highest first:
  - rst_i: all registered outputs and the counter are cleared to 0.
  - Stall_i: every register holds, and the counter holds. Hazard_o is still evaluated from the held state and the current ID inputs.
  - Hazard_o: a bubble is loaded. All control outputs, data and address fields are set to 0, Valid_o is set to 0, and the counter increments unless it is already at all-ones.
  - Otherwise: all inputs are loaded and Valid_o is set to 1.
- The bubble is forced internally; correctness must not depend on decode also zeroing its controls.
- Branch and jump resolve in ID, so Branch/Jump are not carried into this register.

## Timing
- Reset values:
  - Every output register is 0, including Valid_o and Bubble_cnt_o.
  - Hazard_o is 0.
  - PCWrite_o and IFIDWrite_o are 1 unless Stall_i is asserted.
- Latency: inputs appear on outputs 1 cycle after an unstalled edge.
- A load-use inserts exactly one bubble. After the bubble edge, MemRead_o is 0, so Hazard_o deasserts and the held ID instruction loads on the next edge.
- Hazard plus Stall_i in the same cycle: the stall wins. No bubble is inserted and the counter does not change. The bubble is inserted on the first edge after Stall_i drops, provided the hazard persists.
- Back-to-back loads with dependents produce one bubble per dependent load.
- Asserting rst_i mid-stall or mid-hazard clears state on that edge, with no partial update.

## Structure
- A shared package mips_pkg holds:
  - ALUOp encodings (ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b11).
  - Opcode constants (R-type, addi, lw, sw, beq, j).
  - Register-number width (5) and data width (32).
- One combinational sub-module, hazard_detect, implements the Hazard_o equation. It is reused by the top-level wiring.

## Test plan
- Reset: hold rst_i for 2 cycles with all inputs nonzero. Required: all outputs 0, Bubble_cnt_o=0, PCWrite_o=IFIDWrite_o=1.
- Normal load: present R-type controls (RegDst=1, ALUOp=2'b11, RegWrite=1) with RS_data=0x5, RT_data=0xA, RD=3. Required: next cycle outputs match and Valid_o=1.
- Load-use: EX holds lw (MemRead_o=1, RT_addr_o=9); ID presents RS_addr_i=9. Required: Hazard_o=1 and PCWrite_o=0 in that cycle. Next edge: Valid_o=0, all controls 0, Bubble_cnt_o=1. Following cycle: Hazard_o=0.
- Zero register: EX holds lw with RT_addr_o=0; ID presents RS_addr_i=0. Required: Hazard_o=0 and a normal load.
- Stall overlap: hazard pending while Stall_i=1 for 3 cycles. Required: outputs and counter unchanged and PCWrite_o=0 throughout. First edge after release: bubble, Bubble_cnt_o incremented by 1.
- Saturation with CNT_W=3: drive 9 load-use hazards. Required: Bubble_cnt_o stops at 7.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS encodings and widths for the pipeline
package mips_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard detection between EX and ID
module hazard_detect
    import mips_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard
);

    // The rt match is conservative: an I-type whose rt is a destination can stall once.
    assign hazard = ex_valid & ex_mem_read & (ex_rt != '0) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with bubble insertion and stall
module id_ex_pipe
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              Stall_i,
    input  logic              RegDst_i,
    input  logic              ALUSrc_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemWrite_i,
    input  logic              MemRead_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] RS_data_i,
    input  logic [DATA_W-1:0] RT_data_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [REG_W-1:0]  RS_addr_i,
    input  logic [REG_W-1:0]  RT_addr_i,
    input  logic [REG_W-1:0]  RD_addr_i,
    output logic              RegDst_o,
    output logic              ALUSrc_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemWrite_o,
    output logic              MemRead_o,
    output logic [1:0]        ALUOp_o,
    output logic [DATA_W-1:0] RS_data_o,
    output logic [DATA_W-1:0] RT_data_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [REG_W-1:0]  RS_addr_o,
    output logic [REG_W-1:0]  RT_addr_o,
    output logic [REG_W-1:0]  RD_addr_o,
    output logic              Valid_o,
    output logic              Hazard_o,
    output logic              PCWrite_o,
    output logic              IFIDWrite_o,
    output logic [CNT_W-1:0]  Bubble_cnt_o
);

    hazard_detect u_hazard (
        .ex_valid    (Valid_o),
        .ex_mem_read (MemRead_o),
        .ex_rt       (RT_addr_o),
        .id_rs       (RS_addr_i),
        .id_rt       (RT_addr_i),
        .hazard      (Hazard_o)
    );

    assign PCWrite_o   = ~(Hazard_o | Stall_i);
    assign IFIDWrite_o = ~(Hazard_o | Stall_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || (!Stall_i && Hazard_o)) begin
            // Bubble is forced here so EX is safe even if decode did not zero its controls.
            RegDst_o   <= 1'b0;
            ALUSrc_o   <= 1'b0;
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            MemWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
            ALUOp_o    <= '0;
            RS_data_o  <= '0;
            RT_data_o  <= '0;
            Imm_o      <= '0;
            RS_addr_o  <= '0;
            RT_addr_o  <= '0;
            RD_addr_o  <= '0;
            Valid_o    <= 1'b0;
            if (rst_i) begin
                Bubble_cnt_o <= '0;
            end else if (Bubble_cnt_o != '1) begin
                Bubble_cnt_o <= Bubble_cnt_o + CNT_W'(1);
            end
        end else if (!Stall_i) begin
            RegDst_o   <= RegDst_i;
            ALUSrc_o   <= ALUSrc_i;
            RegWrite_o <= RegWrite_i;
            MemtoReg_o <= MemtoReg_i;
            MemWrite_o <= MemWrite_i;
            MemRead_o  <= MemRead_i;
            ALUOp_o    <= ALUOp_i;
            RS_data_o  <= RS_data_i;
            RT_data_o  <= RT_data_i;
            Imm_o      <= Imm_i;
            RS_addr_o  <= RS_addr_i;
            RT_addr_o  <= RT_addr_i;
            RD_addr_o  <= RD_addr_i;
            Valid_o    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - directed self-checking bench for id_ex_pipe
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic        reg_dst, alu_src, reg_write, mem_to_reg, mem_write, mem_read;
    logic [1:0]  alu_op;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        reg_dst_q, alu_src_q, reg_write_q, mem_to_reg_q, mem_write_q, mem_read_q;
    logic [1:0]  alu_op_q;
    logic [31:0] rs_data_q, rt_data_q, imm_q;
    logic [4:0]  rs_addr_q, rt_addr_q, rd_addr_q;
    logic        valid, hazard, pc_write, ifid_write;
    logic [2:0]  bubble_cnt;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    id_ex_pipe #(.CNT_W(3)) dut (
        .clk_i(clk), .rst_i(rst), .Stall_i(stall),
        .RegDst_i(reg_dst), .ALUSrc_i(alu_src), .RegWrite_i(reg_write),
        .MemtoReg_i(mem_to_reg), .MemWrite_i(mem_write), .MemRead_i(mem_read),
        .ALUOp_i(alu_op), .RS_data_i(rs_data), .RT_data_i(rt_data), .Imm_i(imm),
        .RS_addr_i(rs_addr), .RT_addr_i(rt_addr), .RD_addr_i(rd_addr),
        .RegDst_o(reg_dst_q), .ALUSrc_o(alu_src_q), .RegWrite_o(reg_write_q),
        .MemtoReg_o(mem_to_reg_q), .MemWrite_o(mem_write_q), .MemRead_o(mem_read_q),
        .ALUOp_o(alu_op_q), .RS_data_o(rs_data_q), .RT_data_o(rt_data_q), .Imm_o(imm_q),
        .RS_addr_o(rs_addr_q), .RT_addr_o(rt_addr_q), .RD_addr_o(rd_addr_q),
        .Valid_o(valid), .Hazard_o(hazard), .PCWrite_o(pc_write), .IFIDWrite_o(ifid_write),
        .Bubble_cnt_o(bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] rsd, input logic [31:0] rtd);
        reg_dst = 1'b1; alu_src = 1'b0; reg_write = 1'b1; mem_to_reg = 1'b0;
        mem_write = 1'b0; mem_read = 1'b0; alu_op = 2'b11;
        rs_data = rsd; rt_data = rtd; imm = 32'h0;
        rs_addr = rs; rt_addr = rt; rd_addr = rd;
    endtask

    task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] off);
        reg_dst = 1'b0; alu_src = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1;
        mem_write = 1'b0; mem_read = 1'b1; alu_op = 2'b00;
        rs_data = 32'h100; rt_data = 32'h0; imm = off;
        rs_addr = rs; rt_addr = rt; rd_addr = 5'd0;
    endtask

    function automatic logic [6:0] ctl_q();
        return {reg_dst_q, alu_src_q, reg_write_q, mem_to_reg_q, mem_write_q, mem_read_q, valid};
    endfunction

    initial begin
        logic [2:0] exp_cnt;

        // Reset with every ID input nonzero
        rst = 1'b1; stall = 1'b0;
        reg_dst = 1; alu_src = 1; reg_write = 1; mem_to_reg = 1; mem_write = 1; mem_read = 1;
        alu_op = 2'b11; rs_data = 32'hFFFF_FFFF; rt_data = 32'h1234_5678; imm = 32'h55;
        rs_addr = 5'd7; rt_addr = 5'd8; rd_addr = 5'd9;
        step(); step();
        chk("rst_ctl", {25'h0, ctl_q()}, 32'h0);
        chk("rst_aluop", {30'h0, alu_op_q}, 32'h0);
        chk("rst_rs_data", rs_data_q, 32'h0);
        chk("rst_rt_data", rt_data_q, 32'h0);
        chk("rst_imm", imm_q, 32'h0);
        chk("rst_addrs", {17'h0, rs_addr_q, rt_addr_q, rd_addr_q}, 32'h0);
        chk("rst_cnt", {29'h0, bubble_cnt}, 32'h0);
        chk("rst_hazard", {31'h0, hazard}, 32'h0);
        chk("rst_pcw", {30'h0, pc_write, ifid_write}, 32'h3);

        // Normal R-type load
        rst = 1'b0;
        set_rtype(5'd1, 5'd2, 5'd3, 32'h5, 32'hA);
        step();
        chk("rt_ctl", {25'h0, ctl_q()}, 32'b1010001);
        chk("rt_aluop", {30'h0, alu_op_q}, 32'h3);
        chk("rt_rs_data", rs_data_q, 32'h5);
        chk("rt_rt_data", rt_data_q, 32'hA);
        chk("rt_addrs", {17'h0, rs_addr_q, rt_addr_q, rd_addr_q}, {17'h0, 5'd1, 5'd2, 5'd3});

        // Load-use: lw r9 in EX, dependent rs=9 in ID
        set_lw(5'd4, 5'd9, 32'h8);
        chk("lw_no_hazard", {31'h0, hazard}, 32'h0);
        step();
        chk("lw_loaded", {25'h0, ctl_q()}, 32'b0111011);
        chk("lw_rt_addr", {27'h0, rt_addr_q}, 32'd9);
        set_rtype(5'd9, 5'd5, 5'd6, 32'h11, 32'h22);
        chk("lu_hazard", {31'h0, hazard}, 32'h1);
        chk("lu_pcw", {30'h0, pc_write, ifid_write}, 32'h0);
        step();
        chk("bub_ctl", {25'h0, ctl_q()}, 32'h0);
        chk("bub_data", rs_data_q | rt_data_q | imm_q, 32'h0);
        chk("bub_cnt", {29'h0, bubble_cnt}, 32'h1);
        chk("bub_hazard_clr", {31'h0, hazard}, 32'h0);
        chk("bub_pcw", {30'h0, pc_write, ifid_write}, 32'h3);
        step();
        chk("dep_loaded", {17'h0, rs_addr_q, rt_addr_q, rd_addr_q}, {17'h0, 5'd9, 5'd5, 5'd6});
        chk("dep_valid", {31'h0, valid}, 32'h1);

        // Zero register never hazards
        set_lw(5'd1, 5'd0, 32'h4);
        step();
        set_rtype(5'd0, 5'd0, 5'd12, 32'h3, 32'h4);
        chk("zero_hazard", {31'h0, hazard}, 32'h0);
        step();
        chk("zero_load", {26'h0, valid, rd_addr_q}, {26'h0, 1'b1, 5'd12});
        chk("zero_cnt", {29'h0, bubble_cnt}, 32'h1);

        // Hazard overlapping a 3-cycle stall
        set_lw(5'd2, 5'd9, 32'h10);
        step();
        set_rtype(5'd3, 5'd9, 5'd4, 32'h7, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stl_pcw", {30'h0, pc_write, ifid_write}, 32'h0);
            chk("stl_hazard", {31'h0, hazard}, 32'h1);
            step();
            chk("stl_hold", {25'h0, ctl_q()}, 32'b0111011);
            chk("stl_imm", imm_q, 32'h10);
            chk("stl_cnt", {29'h0, bubble_cnt}, 32'h1);
        end
        stall = 1'b0;
        chk("rel_hazard", {31'h0, hazard}, 32'h1);
        step();
        chk("rel_bubble", {31'h0, valid}, 32'h0);
        chk("rel_cnt", {29'h0, bubble_cnt}, 32'h2);
        step();
        chk("rel_dep", {26'h0, valid, rd_addr_q}, {26'h0, 1'b1, 5'd4});

        // Saturation: nine more load-use bubbles on a 3-bit counter
        exp_cnt = 3'd2;
        for (int i = 0; i < 9; i++) begin
            set_lw(5'd1, 5'd9, 32'h0);
            step();
            set_rtype(5'd9, 5'd2, 5'd3, 32'h1, 32'h2);
            step();
            exp_cnt = (exp_cnt == 3'd7) ? 3'd7 : exp_cnt + 3'd1;
            chk("sat_cnt", {29'h0, bubble_cnt}, {29'h0, exp_cnt});
        end
        chk("sat_final", {29'h0, bubble_cnt}, 32'h7);

        // Reset asserted mid-stall with a pending hazard
        step();
        set_lw(5'd1, 5'd9, 32'h0);
        step();
        set_rtype(5'd9, 5'd2, 5'd3, 32'h1, 32'h2);
        stall = 1'b1;
        rst = 1'b1;
        step();
        chk("rst_stl_ctl", {25'h0, ctl_q()}, 32'h0);
        chk("rst_stl_cnt", {29'h0, bubble_cnt}, 32'h0);
        chk("rst_stl_pcw", {30'h0, pc_write, ifid_write}, 32'h0);
        rst = 1'b0; stall = 1'b0;
        step();
        chk("post_rst_load", {26'h0, valid, rs_addr_q}, {26'h0, 1'b1, 5'd9});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
